// File: rtl/sram22_arb2_if.sv
// ============================================================================
// Module   : sram22_arb2_if
// Purpose  : Bundles the two requester ports and the SRAM22 macro pins of sram22_arb2.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sram22_arb2_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int WMASK_WIDTH = 8
);
   logic                   req0_valid;
   logic                   req0_ready;
   logic                   req0_we;
   logic [WMASK_WIDTH-1:0] req0_wmask;
   logic [ADDR_WIDTH-1:0]  req0_addr;
   logic [DATA_WIDTH-1:0]  req0_wdata;
   logic                   rsp0_valid;
   logic                   rsp0_ready;
   logic [DATA_WIDTH-1:0]  rsp0_rdata;

   logic                   req1_valid;
   logic                   req1_ready;
   logic                   req1_we;
   logic [WMASK_WIDTH-1:0] req1_wmask;
   logic [ADDR_WIDTH-1:0]  req1_addr;
   logic [DATA_WIDTH-1:0]  req1_wdata;
   logic                   rsp1_valid;
   logic                   rsp1_ready;
   logic [DATA_WIDTH-1:0]  rsp1_rdata;

   logic                   sram_we;
   logic [WMASK_WIDTH-1:0] sram_wmask;
   logic [ADDR_WIDTH-1:0]  sram_addr;
   logic [DATA_WIDTH-1:0]  sram_din;
   logic [DATA_WIDTH-1:0]  sram_dout;

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_we, req0_wmask, req0_addr, req0_wdata, rsp0_ready,
      output req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_valid, req1_we, req1_wmask, req1_addr, req1_wdata, rsp1_ready,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output sram_we, sram_wmask, sram_addr, sram_din,
      input  sram_dout
   );

   // Requesters plus macro side.
   modport master (
      output req0_valid, req0_we, req0_wmask, req0_addr, req0_wdata, rsp0_ready,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      output req1_valid, req1_we, req1_wmask, req1_addr, req1_wdata, rsp1_ready,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  sram_we, sram_wmask, sram_addr, sram_din,
      output sram_dout
   );
endinterface

`default_nettype wire

// File: rtl/sram22_arb2.sv
// ============================================================================
// Module   : sram22_arb2
// Purpose  : Two-port arbiter/sequencer for one SRAM22 macro with per-port
//            read response registers. SRAM22_ARB_RR_EN selects round-robin.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram22_arb2 #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int WMASK_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   sram22_arb2_if.slave bus
);

   logic [1:0]                   req_valid;
   logic [1:0]                   req_we;
   logic [1:0]                   rsp_ready;
   logic [1:0][WMASK_WIDTH-1:0]  req_wmask;
   logic [1:0][ADDR_WIDTH-1:0]   req_addr;
   logic [1:0][DATA_WIDTH-1:0]   req_wdata;

   logic [1:0]                   slot_free;
   logic [1:0]                   eligible;
   logic [1:0]                   grant;
   logic                         gnt_any;
   logic                         gnt_port;

   logic                         pend_v_q, pend_v_d;
   logic                         pend_port_q, pend_port_d;
   logic [1:0]                   rsp_valid_q, rsp_valid_d;
   logic [1:0][DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef SRAM22_ARB_RR_EN
   logic                         rr_ptr_q, rr_ptr_d;
`endif

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign req_we    = {bus.req1_we,    bus.req0_we};
   assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
   assign req_wmask = {bus.req1_wmask, bus.req0_wmask};
   assign req_addr  = {bus.req1_addr,  bus.req0_addr};
   assign req_wdata = {bus.req1_wdata, bus.req0_wdata};

   // A read needs the port's single response slot; writes never do.
   always_comb begin
      slot_free[0] = !rsp_valid_q[0] && !(pend_v_q && !pend_port_q);
      slot_free[1] = !rsp_valid_q[1] && !(pend_v_q &&  pend_port_q);
      eligible     = req_valid & (req_we | slot_free);
      gnt_any      = |eligible;
`ifdef SRAM22_ARB_RR_EN
      gnt_port     = (&eligible) ? rr_ptr_q : eligible[1];
`else
      gnt_port     = !eligible[0];
`endif
      grant        = 2'b00;
      if (gnt_any) begin
         grant = gnt_port ? 2'b10 : 2'b01;
      end
   end

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.sram_we    = gnt_any ? req_we[gnt_port]    : 1'b0;
   assign bus.sram_wmask = gnt_any ? req_wmask[gnt_port] : '0;
   assign bus.sram_addr  = gnt_any ? req_addr[gnt_port]  : '0;
   assign bus.sram_din   = gnt_any ? req_wdata[gnt_port] : '0;

   always_comb begin
      pend_v_d    = 1'b0;
      pend_port_d = pend_port_q;
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rsp_rdata_d = rsp_rdata_q;
`ifdef SRAM22_ARB_RR_EN
      rr_ptr_d    = rr_ptr_q;
      if (gnt_any) begin
         rr_ptr_d = !gnt_port;
      end
`endif
      // Macro dout is valid one edge after the read was sampled.
      if (pend_v_q) begin
         rsp_valid_d[pend_port_q] = 1'b1;
         rsp_rdata_d[pend_port_q] = bus.sram_dout;
      end
      if (gnt_any && !req_we[gnt_port]) begin
         pend_v_d    = 1'b1;
         pend_port_d = gnt_port;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v_q    <= 1'b0;
         pend_port_q <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
`ifdef SRAM22_ARB_RR_EN
         rr_ptr_q    <= 1'b0;
`endif
      end else begin
         pend_v_q    <= pend_v_d;
         pend_port_q <= pend_port_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef SRAM22_ARB_RR_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   assign bus.rsp0_valid = rsp_valid_q[0];
   assign bus.rsp1_valid = rsp_valid_q[1];
   assign bus.rsp0_rdata = rsp_rdata_q[0];
   assign bus.rsp1_rdata = rsp_rdata_q[1];

endmodule

`default_nettype wire

// File: tb/tb_sram22_arb2.sv
// ============================================================================
// Module   : tb_sram22_arb2
// Purpose  : Self-checking bench for sram22_arb2 with an SRAM22 macro model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram22_arb2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram22_arb2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(8)) bus ();

   sram22_arb2 #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Requester stimulus
   bit   [1:0]  iv, iwe, irr;
   logic [7:0]  im [2];
   logic [8:0]  ia [2];
   logic [31:0] id [2];

   assign bus.req0_valid = iv[0];
   assign bus.req0_we    = iwe[0];
   assign bus.req0_wmask = im[0];
   assign bus.req0_addr  = ia[0];
   assign bus.req0_wdata = id[0];
   assign bus.rsp0_ready = irr[0];
   assign bus.req1_valid = iv[1];
   assign bus.req1_we    = iwe[1];
   assign bus.req1_wmask = im[1];
   assign bus.req1_addr  = ia[1];
   assign bus.req1_wdata = id[1];
   assign bus.rsp1_ready = irr[1];

   // SRAM22 macro: nibble-masked write, registered read
   logic [31:0] mac_mem [512];
   always @(posedge clk) begin
      if (bus.sram_we) begin
         for (int n = 0; n < 8; n++) begin
            if (bus.sram_wmask[n]) mac_mem[bus.sram_addr][4*n +: 4] <= bus.sram_din[4*n +: 4];
         end
      end
      bus.sram_dout <= mac_mem[bus.sram_addr];
   end

   // Reference model: memory contents, one pending read and one response slot per port
   logic [31:0] ref_mem [512];
   bit          m_pend   [2];
   logic [31:0] m_pend_d [2];
   bit          m_rsp_v  [2];
   logic [31:0] m_rsp_d  [2];
`ifdef SRAM22_ARB_RR_EN
   bit          m_ptr;
`endif

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [1:0]  last_ready;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_clear();
      for (int p = 0; p < 2; p++) begin
         m_pend[p]   = 1'b0;
         m_pend_d[p] = '0;
         m_rsp_v[p]  = 1'b0;
         m_rsp_d[p]  = '0;
      end
`ifdef SRAM22_ARB_RR_EN
      m_ptr = 1'b0;
`endif
   endtask

   task automatic set_req(input int p, input bit v, input bit we, input logic [7:0] m,
                          input logic [8:0] a, input logic [31:0] d);
      iv[p] = v; iwe[p] = we; im[p] = m; ia[p] = a; id[p] = d;
   endtask

   // One clock: check combinational and registered outputs, then advance the model.
   task automatic step();
      bit [1:0]    elig;
      bit [1:0]    g;
      bit          gp;
      logic [49:0] exp_sram;
      #1;
      for (int p = 0; p < 2; p++) elig[p] = iv[p] && (iwe[p] || (!m_rsp_v[p] && !m_pend[p]));
      gp = 1'b0;
      if (elig == 2'b10) gp = 1'b1;
`ifdef SRAM22_ARB_RR_EN
      if (elig == 2'b11) gp = m_ptr;
`endif
      g        = (elig == 2'b00) ? 2'b00 : (gp ? 2'b10 : 2'b01);
      exp_sram = (elig == 2'b00) ? '0 : {iwe[gp], im[gp], ia[gp], id[gp]};
      last_ready = {bus.req1_ready, bus.req0_ready};
      check_eq("ready", {62'd0, last_ready}, {62'd0, g});
      check_eq("sram_drive", {14'd0, bus.sram_we, bus.sram_wmask, bus.sram_addr, bus.sram_din},
               {14'd0, exp_sram});
      check_eq("rsp_valid", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, {62'd0, m_rsp_v[1], m_rsp_v[0]});
      check_eq("rsp0_rdata", {32'd0, bus.rsp0_rdata}, {32'd0, m_rsp_d[0]});
      check_eq("rsp1_rdata", {32'd0, bus.rsp1_rdata}, {32'd0, m_rsp_d[1]});
      @(posedge clk);
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            if (m_rsp_v[p] && irr[p]) m_rsp_v[p] = 1'b0;
            if (m_pend[p]) begin
               m_rsp_v[p] = 1'b1;
               m_rsp_d[p] = m_pend_d[p];
               m_pend[p]  = 1'b0;
            end
         end
         if (elig != 2'b00) begin
            if (iwe[gp]) begin
               for (int n = 0; n < 8; n++)
                  if (im[gp][n]) ref_mem[ia[gp]][4*n +: 4] = id[gp][4*n +: 4];
            end else begin
               m_pend[gp]   = 1'b1;
               m_pend_d[gp] = ref_mem[ia[gp]];
            end
`ifdef SRAM22_ARB_RR_EN
            m_ptr = !gp;
`endif
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      iv = 2'b00;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mac_mem[i] <= '0;
         ref_mem[i] = '0;
      end
      model_clear();
      iv = '0; iwe = '0; irr = '0;
      for (int p = 0; p < 2; p++) set_req(p, 1'b0, 1'b0, 8'h00, 9'h000, 32'h0);

      // Reset state
      step();
      step();
      rst_n = 1'b1;
      step();

      // Contention: both ports read continuously, responses drained each cycle
      irr = 2'b11;
      for (int c = 0; c < 30; c++) begin
         set_req(0, 1'b1, 1'b0, 8'h00, 9'($urandom_range(0, 15)), 32'h0);
         set_req(1, 1'b1, 1'b0, 8'h00, 9'($urandom_range(0, 15)), 32'h0);
         step();
         if (c == 0) check_eq("cont_c0", {62'd0, last_ready}, 64'h1);
         if (c == 1) check_eq("cont_c1", {62'd0, last_ready}, 64'h2);
         if (c == 2) check_eq("cont_c2", {62'd0, last_ready}, 64'h0);
         if (c == 3) check_eq("cont_c3", {62'd0, last_ready}, 64'h1);
      end
      idle(4);

      // Write then read on port 0
      irr = 2'b00;
      set_req(0, 1'b1, 1'b1, 8'hFF, 9'h1A5, 32'hDEADBEEF); step();
      set_req(0, 1'b1, 1'b0, 8'h00, 9'h1A5, 32'h0);        step();
      idle(1);
      check_eq("wr_rd_valid", {63'd0, bus.rsp0_valid}, 64'h1);
      check_eq("wr_rd_data", {32'd0, bus.rsp0_rdata}, 64'hDEADBEEF);
      irr = 2'b11;
      idle(2);

      // Nibble mask
      set_req(0, 1'b1, 1'b1, 8'hFF, 9'h010, 32'h00000000); step();
      set_req(0, 1'b1, 1'b1, 8'h0F, 9'h010, 32'h12345678); step();
      set_req(0, 1'b1, 1'b0, 8'h00, 9'h010, 32'h0);        step();
      idle(1);
      check_eq("nibble_data", {32'd0, bus.rsp0_rdata}, 64'h00005678);
      idle(2);

      // Backpressure on port 1
      irr = 2'b00;
      set_req(1, 1'b1, 1'b1, 8'hFF, 9'h003, 32'h5A5A0003); step();
      set_req(1, 1'b1, 1'b0, 8'h00, 9'h003, 32'h0);        step();
      step();
      for (int c = 0; c < 5; c++) begin
         step();
         check_eq("bp_read_blocked", {62'd0, last_ready}, 64'h0);
         check_eq("bp_valid", {63'd0, bus.rsp1_valid}, 64'h1);
         check_eq("bp_data", {32'd0, bus.rsp1_rdata}, 64'h5A5A0003);
      end
      set_req(1, 1'b1, 1'b1, 8'hFF, 9'h004, 32'h00000004); step();
      check_eq("bp_write_ok", {62'd0, last_ready}, 64'h2);
      irr = 2'b11;
      idle(3);

      // Write on port 0, read of the same word on port 1 next cycle
      set_req(0, 1'b1, 1'b1, 8'hFF, 9'h0AA, 32'hCAFEF00D); step();
      iv[0] = 1'b0;
      set_req(1, 1'b1, 1'b0, 8'h00, 9'h0AA, 32'h0);        step();
      idle(1);
      check_eq("hazard_data", {32'd0, bus.rsp1_rdata}, 64'hCAFEF00D);
      idle(2);

      // Reset with a response waiting
      irr = 2'b00;
      set_req(0, 1'b1, 1'b0, 8'h00, 9'h1A5, 32'h0); step();
      idle(1);
      check_eq("rst_pre_valid", {63'd0, bus.rsp0_valid}, 64'h1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_valid_drop", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'h0);
      model_clear();
      idle(2);
      rst_n = 1'b1;
      idle(3);
      irr = 2'b11;
      set_req(0, 1'b1, 1'b0, 8'h00, 9'h1A5, 32'h0); step();
      idle(1);
      check_eq("post_rst_data", {32'd0, bus.rsp0_rdata}, 64'hDEADBEEF);
      idle(2);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++) begin
            set_req(p, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
                    8'($urandom), 9'($urandom_range(0, 15)), $urandom);
            irr[p] = ($urandom_range(0, 9) < 6);
         end
         step();
      end
      irr = 2'b11;
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
